// File: rtl/instr_decode_queue_if.sv
// Handshake and payload bundle for the instruction decode queue.
// The queue sits on the slave side; the producer/consumer pair drives the master side.
interface instr_decode_queue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [2:0]      out_func3;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [6:0]      out_func7;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_func3, out_rs1,
           out_rs2, out_func7, out_imm, out_pc, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_func3, out_rs1,
           out_rs2, out_func7, out_imm, out_pc, out_fmt, out_illegal
  );
endinterface

// File: rtl/instr_decode_queue.sv
// RISC-V instruction field/immediate decoder feeding a small circular buffer.
// Decode happens on the way in, so the head entry drives out_* straight from storage.
module instr_decode_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0040_0000)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  instr_decode_queue_if.slave      q,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      func3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      func7;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } entry_t;

  function automatic entry_t decode_f(input logic [31:0] instr, input logic [XLEN-1:0] pc);
    entry_t e;
    e.opcode = instr[6:0];
    e.rd     = instr[11:7];
    e.func3  = instr[14:12];
    e.rs1    = instr[19:15];
    e.rs2    = instr[24:20];
    e.func7  = instr[31:25];
    e.pc     = pc;
    e.fmt    = FMT_NONE;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        7'b0110011:                                     e.fmt = FMT_R;
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: e.fmt = FMT_I;
        7'b0100011:                                     e.fmt = FMT_S;
        7'b1100011:                                     e.fmt = FMT_B;
        7'b0110111, 7'b0010111:                         e.fmt = FMT_U;
        7'b1101111:                                     e.fmt = FMT_J;
        // RV64 word-sized ops exist only on the 64-bit datapath
        7'b0011011: e.fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
        7'b0111011: e.fmt = (XLEN == 64) ? FMT_R : FMT_NONE;
        default:    e.fmt = FMT_NONE;
      endcase
    end else begin
      e.fmt = FMT_NONE;
    end
    e.illegal = (e.fmt == FMT_NONE);
    case (e.fmt)
      FMT_I:   e.imm = XLEN'($signed(instr[31:20]));
      FMT_S:   e.imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      FMT_B:   e.imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      FMT_U:   e.imm = XLEN'($signed({instr[31:12], 12'h000}));
      FMT_J:   e.imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      default: e.imm = {XLEN{1'b0}};
    endcase
    return e;
  endfunction

  entry_t          mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            in_ready_s;
  logic            out_valid_s;
  logic            push_s;
  logic            pop_s;
  entry_t          wr_entry_s;
  entry_t          head_s;

  assign in_ready_s  = (count_r < CW'(DEPTH));
  assign out_valid_s = (count_r != {CW{1'b0}});
  assign push_s      = q.in_valid && in_ready_s;
  assign pop_s       = out_valid_s && q.out_ready;
  assign wr_entry_s  = decode_f(q.in_instr, q.in_pc);
  assign head_s      = mem_r[rd_ptr_r];
  assign count       = count_r;
  assign q.in_ready  = in_ready_s;
  assign q.out_valid = out_valid_s;

  // Occupancy and pointer state; flush outranks both push and pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= wr_entry_s;
    end
  end

  // Head presentation, masked to the idle pattern while empty.
  always_comb begin
    q.out_opcode  = 7'd0;
    q.out_rd      = 5'd0;
    q.out_func3   = 3'd0;
    q.out_rs1     = 5'd0;
    q.out_rs2     = 5'd0;
    q.out_func7   = 7'd0;
    q.out_imm     = {XLEN{1'b0}};
    q.out_pc      = RESET_PC;
    q.out_fmt     = FMT_NONE;
    q.out_illegal = 1'b0;
    if (out_valid_s) begin
      q.out_opcode  = head_s.opcode;
      q.out_rd      = head_s.rd;
      q.out_func3   = head_s.func3;
      q.out_rs1     = head_s.rs1;
      q.out_rs2     = head_s.rs2;
      q.out_func7   = head_s.func7;
      q.out_imm     = head_s.imm;
      q.out_pc      = head_s.pc;
      q.out_fmt     = head_s.fmt;
      q.out_illegal = head_s.illegal;
    end else begin
      q.out_pc      = RESET_PC;
      q.out_fmt     = FMT_NONE;
    end
  end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue: a 32-bit and a 64-bit instance share
// one stimulus stream so width-dependent decoding can be compared side by side.
module tb_instr_decode_queue;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic [1:0]  count_a;
  logic [1:0]  count_b;
  int          errors;
  int          checks;

  instr_decode_queue_if #(.XLEN(32)) a_if ();
  instr_decode_queue_if #(.XLEN(64)) b_if ();

  instr_decode_queue #(.XLEN(32), .DEPTH(2)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .q       (a_if),
    .count   (count_a)
  );

  instr_decode_queue #(.XLEN(64), .DEPTH(2)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .q       (b_if),
    .count   (count_b)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [31:0] instr, input logic [31:0] pc,
                       input logic ordy);
    a_if.in_valid  = vld;
    a_if.in_instr  = instr;
    a_if.in_pc     = pc;
    a_if.out_ready = ordy;
    b_if.in_valid  = vld;
    b_if.in_instr  = instr;
    b_if.in_pc     = {32'h0000_0000, pc};
    b_if.out_ready = ordy;
  endtask

  task automatic step(input logic vld, input logic [31:0] instr, input logic [31:0] pc,
                      input logic ordy);
    drive(vld, instr, pc, ordy);
    @(posedge clock);
    #1;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    clock   = 1'b0;
    reset_n = 1'b0;
    flush   = 1'b0;
    drive(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);
    #12;
    chk("rst_valid",  {63'd0, a_if.out_valid}, 64'd0);
    chk("rst_ready",  {63'd0, a_if.in_ready}, 64'd1);
    chk("rst_count",  {62'd0, count_a}, 64'd0);
    chk("rst_pc",     {32'd0, a_if.out_pc}, 64'h0040_0000);
    chk("rst_fmt",    {61'd0, a_if.out_fmt}, 64'd7);
    chk("rst_pc64",   b_if.out_pc, 64'h0040_0000);

    @(negedge clock);
    reset_n = 1'b1;
    // addi x1,x0,5 lands at the head right after the first edge
    step(1'b1, 32'h0050_0093, 32'h0040_0000, 1'b0);
    chk("addi_valid", {63'd0, a_if.out_valid}, 64'd1);
    chk("addi_fmt",   {61'd0, a_if.out_fmt}, 64'd1);
    chk("addi_rd",    {59'd0, a_if.out_rd}, 64'd1);
    chk("addi_imm",   {32'd0, a_if.out_imm}, 64'd5);
    chk("addi_pc",    {32'd0, a_if.out_pc}, 64'h0040_0000);
    chk("addi_op",    {57'd0, a_if.out_opcode}, 64'h13);
    chk("addi_cnt",   {62'd0, count_a}, 64'd1);

    step(1'b1, 32'hFE00_0EE3, 32'h0040_0004, 1'b0);
    chk("full_cnt",   {62'd0, count_a}, 64'd2);
    chk("full_rdy",   {63'd0, a_if.in_ready}, 64'd0);
    chk("full_head",  {59'd0, a_if.out_rd}, 64'd1);

    // third push refused while full
    step(1'b1, 32'h0000_007F, 32'h0040_0008, 1'b0);
    chk("third_cnt",  {62'd0, count_a}, 64'd2);
    chk("third_head", {57'd0, a_if.out_opcode}, 64'h13);

    // pop from full with in_valid high: no slot freed this cycle
    step(1'b1, 32'h0000_007F, 32'h0040_0008, 1'b1);
    chk("beq_cnt",    {62'd0, count_a}, 64'd1);
    chk("beq_fmt",    {61'd0, a_if.out_fmt}, 64'd3);
    chk("beq_imm32",  {32'd0, a_if.out_imm}, 64'h0000_0000_FFFF_FFFC);
    chk("beq_imm64",  b_if.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_rd",     {59'd0, a_if.out_rd}, 64'd29);
    chk("beq_pc",     {32'd0, a_if.out_pc}, 64'h0040_0004);

    // push+pop at count=1 keeps count and order
    step(1'b1, 32'h0000_007F, 32'h0040_0008, 1'b1);
    chk("ill_cnt",    {62'd0, count_a}, 64'd1);
    chk("ill_op",     {57'd0, a_if.out_opcode}, 64'h7F);
    chk("ill_flag",   {63'd0, a_if.out_illegal}, 64'd1);
    chk("ill_fmt",    {61'd0, a_if.out_fmt}, 64'd7);
    chk("ill_imm",    {32'd0, a_if.out_imm}, 64'd0);
    chk("ill_pc",     {32'd0, a_if.out_pc}, 64'h0040_0008);

    step(1'b1, 32'h0000_001B, 32'h0040_000C, 1'b1);
    chk("w32_ill",    {63'd0, a_if.out_illegal}, 64'd1);
    chk("w32_fmt",    {61'd0, a_if.out_fmt}, 64'd7);
    chk("w32_imm",    {32'd0, a_if.out_imm}, 64'd0);
    chk("w64_ill",    {63'd0, b_if.out_illegal}, 64'd0);
    chk("w64_fmt",    {61'd0, b_if.out_fmt}, 64'd1);

    step(1'b1, 32'h00A0_0113, 32'h0040_0010, 1'b0);
    chk("refill_cnt", {62'd0, count_a}, 64'd2);
    chk("refill_rdy", {63'd0, a_if.in_ready}, 64'd0);

    // flush wins over the concurrent push
    flush = 1'b1;
    step(1'b1, 32'h0050_0093, 32'h0040_0014, 1'b0);
    flush = 1'b0;
    chk("fl_cnt",     {62'd0, count_a}, 64'd0);
    chk("fl_valid",   {63'd0, a_if.out_valid}, 64'd0);
    chk("fl_pc",      {32'd0, a_if.out_pc}, 64'h0040_0000);
    chk("fl_rdy",     {63'd0, a_if.in_ready}, 64'd1);
    chk("fl_fmt",     {61'd0, a_if.out_fmt}, 64'd7);
    step(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);
    chk("fl_lost",    {62'd0, count_a}, 64'd0);

    // walk the pointers around the ring with one format per entry
    step(1'b1, 32'h00C0_0193, 32'h0040_0020, 1'b0);
    chk("x3_rd",      {59'd0, a_if.out_rd}, 64'd3);
    chk("x3_imm",     {32'd0, a_if.out_imm}, 64'd12);
    step(1'b1, 32'h1234_52B7, 32'h0040_0024, 1'b1);
    chk("lui_fmt",    {61'd0, a_if.out_fmt}, 64'd4);
    chk("lui_imm",    {32'd0, a_if.out_imm}, 64'h1234_5000);
    chk("lui_rd",     {59'd0, a_if.out_rd}, 64'd5);
    step(1'b1, 32'h0011_2623, 32'h0040_0028, 1'b1);
    chk("sw_fmt",     {61'd0, a_if.out_fmt}, 64'd2);
    chk("sw_imm",     {32'd0, a_if.out_imm}, 64'd12);
    chk("sw_rs1",     {59'd0, a_if.out_rs1}, 64'd2);
    chk("sw_rs2",     {59'd0, a_if.out_rs2}, 64'd1);
    chk("sw_f3",      {61'd0, a_if.out_func3}, 64'd2);
    step(1'b1, 32'h0080_00EF, 32'h0040_002C, 1'b1);
    chk("jal_fmt",    {61'd0, a_if.out_fmt}, 64'd5);
    chk("jal_imm",    {32'd0, a_if.out_imm}, 64'd8);
    chk("jal_pc",     {32'd0, a_if.out_pc}, 64'h0040_002C);
    step(1'b1, 32'h0020_81B3, 32'h0040_0030, 1'b1);
    chk("add_fmt",    {61'd0, a_if.out_fmt}, 64'd0);
    chk("add_imm",    {32'd0, a_if.out_imm}, 64'd0);
    chk("add_rd",     {59'd0, a_if.out_rd}, 64'd3);
    chk("add_rs2",    {59'd0, a_if.out_rs2}, 64'd2);
    chk("add_cnt",    {62'd0, count_a}, 64'd1);

    // asynchronous reset between edges with one entry buffered
    drive(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_valid",   {63'd0, a_if.out_valid}, 64'd0);
    chk("ar_cnt",     {62'd0, count_a}, 64'd0);
    chk("ar_rdy",     {63'd0, a_if.in_ready}, 64'd1);
    chk("ar_pc",      {32'd0, a_if.out_pc}, 64'h0040_0000);
    chk("ar_fmt",     {61'd0, a_if.out_fmt}, 64'd7);
    chk("ar_op",      {57'd0, a_if.out_opcode}, 64'd0);
    chk("ar_imm64",   b_if.out_imm, 64'd0);
    chk("ar_ill",     {63'd0, a_if.out_illegal}, 64'd0);

    @(negedge clock);
    reset_n = 1'b1;
    step(1'b1, 32'h0050_0093, 32'h0040_0040, 1'b0);
    chk("post_valid", {63'd0, a_if.out_valid}, 64'd1);
    chk("post_cnt",   {62'd0, count_a}, 64'd1);
    chk("post_pc",    {32'd0, a_if.out_pc}, 64'h0040_0040);
    chk("post_cnt64", {62'd0, count_b}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
